if_fetch_unit: RTL

Instruction-fetch stage. It generates the PC, runs the request/acknowledge handshake with instruction memory, and presents {instruction, opcode, pc, valid} to the IF/ID pipeline register.
- Honours stall from the hazard unit using a one-entry skid buffer.
- Honours branch redirect from later stages, including discarding a memory response that is already in flight.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_skid_buffer.sv | 42 ++++
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and widths for the instruction-fetch stage, the decoder and the IF/ID register.
package if_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 20;
  localparam int OPC_W   = 4;

  // Opcode sits in the top bits of the instruction word.
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = INSTR_W - OPC_W;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_FETCH = 2'd1;
  localparam state_t S_KILL  = 2'd2;
  localparam state_t S_FULL  = 2'd3;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake, hazard/redirect inputs and the IF/ID-facing outputs of the fetch stage.
interface if_fetch_unit_if;
  import if_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] instruction;
  logic [OPC_W-1:0]   opcode;
  logic [ADDR_W-1:0]  pc_out;
  logic               valid_out;

  modport master (
    output imem_req, imem_addr, instruction, opcode, pc_out, valid_out,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, opcode, pc_out, valid_out,
    output imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/if_skid_buffer.sv
// One-entry instruction+pc holding slot; catches a response that arrives while IF/ID is stalled.
module if_skid_buffer
  import if_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               drain_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  // A redirect clear beats a simultaneous load so no pre-branch word survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, imem request/ack handshake, stall skid buffer and branch kill.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  if_fetch_unit_if.master fetch_if
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pcOut_q, pcOut_d;
  logic               valid_q, valid_d;

  logic               bufLoad, bufDrain, bufValid;
  logic [INSTR_W-1:0] bufInstr;
  logic [ADDR_W-1:0]  bufPc;
  logic               ackValid, branch;

  assign ackValid = fetch_if.imem_ack && req_q;
  assign branch   = fetch_if.branch_taken && (state_q != S_IDLE);

  // Control: a redirect always wins; an in-flight request it orphans is parked in S_KILL.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bufLoad = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (branch) begin
          pc_d    = fetch_if.branch_target;
          state_d = ackValid ? S_FETCH : S_KILL;
        end else if (ackValid) begin
          pc_d = pc_q + 1'b1;
          if (fetch_if.stall) begin
            bufLoad = 1'b1;
            state_d = S_FULL;
          end
        end
      end
      S_KILL: begin
        if (branch) pc_d = fetch_if.branch_target;
        if (ackValid) state_d = S_FETCH;
      end
      S_FULL: begin
        if (branch) begin
          pc_d    = fetch_if.branch_target;
          state_d = S_FETCH;
        end else if (!fetch_if.stall) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID output register: buffered word first, then a live response, else a bubble.
  always_comb begin
    valid_d  = valid_q;
    instr_d  = instr_q;
    pcOut_d  = pcOut_q;
    bufDrain = 1'b0;
    if (branch) begin
      valid_d = 1'b0;
    end else if (!fetch_if.stall) begin
      if (bufValid) begin
        valid_d  = 1'b1;
        instr_d  = bufInstr;
        pcOut_d  = bufPc;
        bufDrain = 1'b1;
      end else if (ackValid && (state_q == S_FETCH)) begin
        valid_d = 1'b1;
        instr_d = fetch_if.imem_rdata;
        pcOut_d = pc_q;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // The killed request keeps its stale address until its ack retires it.
  always_comb begin
    req_d  = (state_d == S_FETCH) || (state_d == S_KILL);
    addr_d = (state_d == S_FETCH) ? pc_d : addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      pcOut_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pcOut_q <= pcOut_d;
      valid_q <= valid_d;
    end
  end

  if_skid_buffer u_skid (
    .clock   (clock),
    .reset   (reset),
    .load_i  (bufLoad),
    .drain_i (bufDrain),
    .clear_i (branch),
    .instr_i (fetch_if.imem_rdata),
    .pc_i    (pc_q),
    .valid_o (bufValid),
    .instr_o (bufInstr),
    .pc_o    (bufPc)
  );

  assign fetch_if.imem_req    = req_q;
  assign fetch_if.imem_addr   = addr_q;
  assign fetch_if.instruction = instr_q;
  assign fetch_if.opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign fetch_if.pc_out      = pcOut_q;
  assign fetch_if.valid_out   = valid_q;

endmodule
